// File: rtl/lomo_pkg.sv
// Shared definitions for the LOMO imitator line blocks: default geometry,
// header flag values and the transmitter FSM state type.
package lomo_pkg;

  localparam int LOMO_WORD_W      = 16;
  localparam int LOMO_N_WORDS     = 20;
  localparam int LOMO_STR_W       = 6;
  localparam int LOMO_FRM_W       = 9;
  localparam int LOMO_STR_PER_FRM = 64;

  localparam logic HDR_FIRST  = 1'b1;
  localparam logic HDR_SECOND = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lomo_state_e;

endpackage

// File: rtl/lomo_sync_edge.sv
// Three-flop synchroniser for an asynchronous reference with a single-cycle
// rising-edge pulse taken from the two settled stages.
module lomo_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [2:0] r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r <= '0;
    else        r <= {r[1:0], din};
  end

  assign pulse = r[1] & ~r[2];

endmodule

// File: rtl/lomo_frame_tx.sv
// LOMO frame transmitter: serialises strings of header/payload words onto
// MK/CLK/DAT, one half-bit per rising edge of the external sync reference.
module lomo_frame_tx
  import lomo_pkg::*;
#(
  parameter int WORD_W      = LOMO_WORD_W,
  parameter int N_WORDS     = LOMO_N_WORDS,
  parameter int STR_W       = LOMO_STR_W,
  parameter int STR_PER_FRM = LOMO_STR_PER_FRM,
  parameter int FRM_W       = LOMO_FRM_W,
  parameter int IDX_W       = $clog2(N_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              en,
  output logic              word_req,
  output logic [IDX_W-1:0]  word_idx,
  input  logic [WORD_W-1:0] word_data,
  output logic              MK,
  output logic              CLK,
  output logic              DAT,
  output logic [FRM_W-1:0]  frm_num,
  output logic [STR_W-1:0]  str_num,
  output logic              busy,
  output lomo_state_e       dbg_state
);

  if (WORD_W != FRM_W + STR_W + 1) begin : g_bad_word_w
    $error("lomo_frame_tx: WORD_W must equal FRM_W + STR_W + 1");
  end
  if ((N_WORDS % 2) != 0 || N_WORDS < 4) begin : g_bad_n_words
    $error("lomo_frame_tx: N_WORDS must be even and at least 4");
  end
  if (STR_PER_FRM > (1 << STR_W) || STR_PER_FRM < 1) begin : g_bad_str_per_frm
    $error("lomo_frame_tx: STR_PER_FRM must be 1..2**STR_W");
  end

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] MID_WORD  = IDX_W'(N_WORDS / 2);
  localparam logic [STR_W-1:0] LAST_STR  = STR_W'(STR_PER_FRM - 1);

  lomo_state_e       state_q, state_d;
  logic              tick;
  logic              phase;
  logic [BIT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  word_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] prefetch;
  logic              req_d;

  logic              last_bit, last_word, next_is_payload;
  logic [IDX_W-1:0]  next_pos;
  logic [STR_W-1:0]  str_next;
  logic [FRM_W-1:0]  frm_next;
  logic [WORD_W-1:0] nxt_word;

  lomo_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sync),
    .pulse (tick)
  );

  always_comb begin
    last_bit        = (bit_cnt == LAST_BIT);
    last_word       = (word_cnt == LAST_WORD);
    next_pos        = last_word ? '0 : word_cnt + 1'b1;
    next_is_payload = (next_pos != '0) && (next_pos != MID_WORD);
    if (str_num == LAST_STR) begin
      str_next = '0;
      frm_next = frm_num + 1'b1;
    end else begin
      str_next = str_num + 1'b1;
      frm_next = frm_num;
    end
  end

  // Word to load at the next word boundary: headers are built from the
  // counters (post-increment when a new string starts), payload from prefetch.
  always_comb begin
    if (state_q == ST_IDLE)       nxt_word = {frm_num, str_num, HDR_FIRST};
    else if (last_word)           nxt_word = {frm_next, str_next, HDR_FIRST};
    else if (next_pos == MID_WORD) nxt_word = {frm_num, str_num, HDR_SECOND};
    else                          nxt_word = prefetch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tick && en) state_d = ST_RUN;
      ST_RUN:  if (tick && !phase && last_bit && last_word && !en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    dbg_state = state_q;
  end

  // Fetch port: word_req is a one-cycle strobe with word_idx valid alongside;
  // the source presents word_data on the cycle after the strobe, where it is
  // captured once into prefetch. There is no back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
      prefetch <= '0;
      req_d    <= 1'b0;
      word_req <= 1'b0;
      word_idx <= '0;
      MK       <= 1'b0;
      CLK      <= 1'b0;
      DAT      <= 1'b0;
      frm_num  <= '0;
      str_num  <= '0;
    end else begin
      word_req <= 1'b0;
      req_d    <= word_req;
      if (req_d) prefetch <= word_data;
      if (tick) begin
        if (state_q == ST_IDLE) begin
          if (en) begin
            shreg    <= nxt_word;
            DAT      <= nxt_word[WORD_W-1];
            CLK      <= 1'b0;
            MK       <= 1'b1;
            phase    <= 1'b1;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end else if (phase) begin
          CLK   <= 1'b1;
          phase <= 1'b0;
          if (last_bit && next_is_payload) begin
            word_req <= 1'b1;
            word_idx <= next_pos;
          end
        end else begin
          CLK   <= 1'b0;
          phase <= 1'b1;
          if (!last_bit) begin
            shreg   <= shreg << 1;
            DAT     <= shreg[WORD_W-2];
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            bit_cnt  <= '0;
            word_cnt <= next_pos;
            if (last_word) begin
              str_num <= str_next;
              frm_num <= frm_next;
              if (en) begin
                shreg <= nxt_word;
                DAT   <= nxt_word[WORD_W-1];
                MK    <= 1'b1;
              end else begin
                DAT   <= 1'b0;
                MK    <= 1'b0;
                phase <= 1'b0;
              end
            end else begin
              shreg <= nxt_word;
              DAT   <= nxt_word[WORD_W-1];
              MK    <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lomo_frame_tx.sv
// Bench for lomo_frame_tx: random sync pacing and payload, line decoded on CLK
// rising edges and compared word by word against a string-level model.
module tb_lomo_frame_tx;
  import lomo_pkg::*;

  localparam int N   = 20;
  localparam int SPF = 4;

  logic        clk, reset, sync, en;
  logic        word_req;
  logic [4:0]  word_idx;
  logic [15:0] word_data;
  logic        MK, CLK, DAT, busy;
  logic [8:0]  frm_num;
  logic [5:0]  str_num;
  lomo_state_e dbg_state;

  lomo_frame_tx #(.STR_PER_FRM(SPF)) dut (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .en        (en),
    .word_req  (word_req),
    .word_idx  (word_idx),
    .word_data (word_data),
    .MK        (MK),
    .CLK       (CLK),
    .DAT       (DAT),
    .frm_num   (frm_num),
    .str_num   (str_num),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // sync reference: random halves of 3..4 clk, period never below 6 clk
  initial begin
    sync = 1'b0;
    forever begin
      repeat ($urandom_range(3, 4)) @(negedge clk);
      sync = ~sync;
    end
  end

  // payload source: answers one cycle after the strobe, garbage otherwise
  logic [15:0] mem[N];
  logic        src_pend = 1'b0;
  logic [4:0]  src_idx  = '0;

  task automatic fill_mem(input bit force_a5c3);
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    if (force_a5c3) mem[1] = 16'hA5C3;
  endtask

  initial begin
    word_data = '0;
    forever begin
      @(negedge clk);
      if (src_pend) word_data = mem[src_idx];
      else          word_data = 16'($urandom);
      src_pend = 1'b0;
      if (reset && word_req) begin
        src_pend = 1'b1;
        src_idx  = word_idx;
      end
    end
  end

  // scoreboard: expected words of whole strings, built from the framing rules
  logic [15:0] exp_q[$];
  logic [15:0] rx_log[$];
  int m_pos = 0, m_str = 0, m_frm = 0;

  function automatic void fill_string();
    for (int p = 0; p < N; p++) begin
      if (p == 0)          exp_q.push_back(16'((m_frm << 7) | (m_str << 1) | 1));
      else if (p == N / 2) exp_q.push_back(16'((m_frm << 7) | (m_str << 1)));
      else                 exp_q.push_back(mem[p]);
    end
  endfunction

  function automatic logic [15:0] log_at(input int i);
    if (i < rx_log.size()) return rx_log[i];
    return 16'hxxxx;
  endfunction

  int          rx_nbits = 0, mk_ticks = 0;
  logic [15:0] rx_word = '0;
  logic        mk_ok = 1'b1;
  logic        clk_prev = 0, mk_prev = 0, dat_prev = 0, req_prev = 0;
  int          rst_bad = 0, dat_glitch = 0, idle_req = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (word_req || MK || CLK || DAT || busy) rst_bad++;
      rx_nbits = 0;
      rx_word  = '0;
      mk_ok    = 1'b1;
      mk_ticks = 0;
      m_pos = 0; m_str = 0; m_frm = 0;
      exp_q.delete();
    end else begin
      if (word_req) begin
        check("req_single", 32'(req_prev), 0);
        check("req_edge", 32'(CLK && !clk_prev), 1);
        check("req_bit", rx_nbits, 15);
        check("req_idx", word_idx, (m_pos + 1) % N);
        if (!busy) idle_req++;
      end
      if (mk_prev && CLK != clk_prev) mk_ticks++;
      if (mk_prev && !MK) begin
        check("mk_len", mk_ticks, 32);
        mk_ticks = 0;
      end
      if (CLK && clk_prev && DAT != dat_prev) dat_glitch++;
      if (CLK && !clk_prev) begin
        rx_word = {rx_word[14:0], DAT};
        if (MK != (m_pos == 0)) mk_ok = 1'b0;
        rx_nbits++;
        if (rx_nbits == 16) begin
          if (m_pos == 0) fill_string();
          check($sformatf("word%0d", m_pos), rx_word, exp_q.pop_front());
          check("mk_word", 32'(mk_ok), 1);
          rx_log.push_back(rx_word);
          rx_nbits = 0;
          mk_ok    = 1'b1;
          m_pos++;
          if (m_pos == N) begin
            m_pos = 0;
            m_str++;
            if (m_str == SPF) begin
              m_str = 0;
              m_frm = (m_frm + 1) % 512;
            end
          end
        end
      end
    end
    req_prev = word_req;
    clk_prev = CLK;
    mk_prev  = MK;
    dat_prev = DAT;
  end

  // main sequence
  initial begin
    reset = 1'b0;
    en    = 1'b0;
    fill_mem(1'b1);
    repeat (50) @(negedge clk);
    check("rst_outputs", 32'({word_req, MK, CLK, DAT, busy, frm_num, str_num, word_idx}), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_quiet", rst_bad, 0);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 30000 && rx_log.size() < 81; i++) @(negedge clk);
    check("wait_rollover", 32'(rx_log.size() >= 81), 1);
    check("hdr_first", log_at(0), 16'h0001);
    check("payload_a5c3", log_at(1), 16'hA5C3);
    check("hdr_mid", log_at(10), 16'h0000);
    check("hdr_rollover", log_at(80), 16'h0081);
    check("frm_after_roll", frm_num, 1);
    check("str_after_roll", str_num, 0);

    for (int i = 0; i < 20000 && !(m_str == 2 && m_pos == 7); i++) @(negedge clk);
    check("wait_word7", 32'(m_str == 2 && m_pos == 7), 1);
    en = 1'b0;
    for (int i = 0; i < 6000 && busy; i++) @(negedge clk);
    check("stop_busy", 32'(busy), 0);
    check("stop_lines", 32'({CLK, DAT, MK}), 0);
    check("stop_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stop_complete", m_pos, 0);
    check("stop_str", str_num, 3);
    check("stop_frm", frm_num, 1);
    repeat (100) @(negedge clk);
    check("idle_hold", 32'({busy, CLK, DAT, MK}), 0);

    fill_mem(1'b0);
    rx_log.delete();
    en = 1'b1;
    for (int i = 0; i < 2000 && rx_log.size() < 1; i++) @(negedge clk);
    check("restart_hdr", log_at(0), 16'h0087);

    for (int i = 0; i < 3000 && !(m_pos == 3 && rx_nbits == 5); i++) @(negedge clk);
    check("wait_bit5", 32'(m_pos == 3 && rx_nbits == 5), 1);
    reset = 1'b0;
    #1;
    check("midrst_lines", 32'({word_req, MK, CLK, DAT, busy}), 0);
    check("midrst_cnt", 32'({frm_num, str_num}), 0);
    repeat (10) @(negedge clk);
    rx_log.delete();
    fill_mem(1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3000 && rx_log.size() < 3; i++) @(negedge clk);
    check("after_rst_hdr", log_at(0), 16'h0001);
    check("after_rst_words", 32'(rx_log.size() >= 3), 1);

    check("dat_stable", dat_glitch, 0);
    check("idle_req", idle_req, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lomo_frame_tx.md
# lomo_frame_tx

Parametrised serial frame transmitter for the LOMO imitator. It emits a framed bit stream on MK/CLK/DAT, paced by an external `sync` reference: every rising edge of `sync` is one half-bit tick. Each string carries two internally generated header words and fetches its payload words from an external word source through a request/capture port. The block sits between the payload register file/RAM and the line drivers.

## Interface

Parameters:
- `WORD_W`, 16: bits per word. Must equal `FRM_W + STR_W + 1` (elaboration error otherwise).
- `N_WORDS`, 20: words per string. Even, at least 4. Word 0 and word `N_WORDS/2` are headers; all others are payload.
- `STR_W`, 6: string counter width.
- `STR_PER_FRM`, 64: strings per frame, at most 2^STR_W.
- `FRM_W`, 9: frame counter width; the counter wraps modulo 2^FRM_W.
- `IDX_W`, $clog2(N_WORDS): payload index width.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `sync`, in, 1: asynchronous half-bit reference.
- `en`, in, 1: transmit enable, synchronous to `clk`.
- `word_req`, out, 1: one-cycle payload fetch strobe.
- `word_idx`, out, IDX_W: word position (1..N_WORDS-1, excluding N_WORDS/2); valid only while `word_req` is high.
- `word_data`, in, WORD_W: payload. Sampled exactly one `clk` after `word_req`.
- `MK`, out, 1: string marker.
- `CLK`, out, 1: line clock.
- `DAT`, out, 1: line data, MSB first.
- `frm_num`, out, FRM_W: current frame number.
- `str_num`, out, STR_W: current string number.
- `busy`, out, 1: high in RUN.

## Operation

- **Tick generation:** `sync` passes through a 3-flop shift register. `tick = r[1] & ~r[2]`, a single-`clk` pulse.
- **Header words:** word 0 is `{frm_num, str_num, 1'b1}`. Word `N_WORDS/2` is `{frm_num, str_num, 1'b0}`.
- **FSM states:** IDLE and RUN. A `phase` bit selects the half-bit within RUN.
- **IDLE:**
  - `CLK`, `DAT` and `MK` are 0.
  - On `tick & en`: load header word 0 into the shift register, drive `DAT` with its MSB, `CLK=0`, `MK=1`, `phase=1`, and go to RUN.
- **RUN, tick with phase=1:**
  - `CLK<=1`, `phase<=0`.
  - If the current bit is the last bit of the word and the next word is payload: `word_req=1` and `word_idx` = next word position in the same cycle.
  - Capture `word_data` into the prefetch register on the following `clk`.
- **RUN, tick with phase=0:**
  - `CLK<=0`, `phase<=1`.
  - If bits remain: shift and drive the next bit on `DAT`.
  - Otherwise advance `word_cnt` and load the next word (header generated internally, or the prefetch register). Drive its MSB.
  - `MK` is 1 for every bit of word 0 and 0 otherwise.
- **End of string** (last bit of word N_WORDS-1, phase=0 tick):
  - `str_num` increments. At `STR_PER_FRM-1` it wraps to 0 and `frm_num` increments, wrapping modulo 2^FRM_W.
  - If `en=0`: go to IDLE, `DAT<=0`, `MK<=0`.
  - Otherwise continue with header word 0 of the new string, including the new counter values.
- **`en` deasserted mid-string:** the current string completes, then the block stops. `en` is sampled only at string boundaries and in IDLE.
- **Counter retention:** counters hold in IDLE. Restarting resumes at the held `frm_num`/`str_num`, from word 0.
- **Reset mid-operation:** all state clears immediately. No partial word is resumed.

## Timing

- **Reset values:** `MK=0`, `CLK=0`, `DAT=0`, `word_req=0`, `word_idx=0`, `busy=0`, `frm_num=0`, `str_num=0`. FSM in IDLE, `phase=0`, synchroniser cleared.
- **Latency:** outputs change 3 `clk` after the first `clk` edge that samples `sync` high (2 synchroniser stages, then 1 register stage).
- **Bit period:** 2 ticks. `DAT` changes only together with `CLK` falling, so it is stable across the `CLK` rising edge.
- **Minimum `sync` period:** 6 `clk`. Behaviour is undefined for faster `sync`.
- **Fetch timing:** fetch happens one bit-half before use. `word_data` needs no hold beyond its capture cycle.
- **Tick coinciding with `en` change:** the `en` value registered on that `clk` edge applies.

## Structure

- Shared package `lomo_pkg`: header flag constants (`HDR_FIRST=1'b1`, `HDR_SECOND=1'b0`), the default `WORD_W`/`N_WORDS`/`STR_W`/`FRM_W` values, and the FSM state enum.
- One sub-module, `lomo_sync_edge`: the 3-flop synchroniser plus rising-edge pulse. It is reused by the future receiver model.

## Test plan

- **Reset values:** hold `reset` low and toggle `sync` → all outputs 0, `word_req` never asserted.
- **First header word:** `en=1` with counters at 0 → first 16 `DAT` bits read 0x0001; `MK=1` for exactly 32 ticks; `CLK` toggles on every tick.
- **Payload fetch:** word source returns 0xA5C3 for index 1 → `word_req` pulses once with `word_idx=1` during bit 15 of word 0, and word 1 on `DAT` reads 0xA5C3 MSB first.
- **Frame roll-over:** run with `STR_PER_FRM=4` for 4 strings → the 5th string header reads `frm_num=1`, `str_num=0`, i.e. 0x0081.
- **Graceful stop:** drop `en` at word 7 of string 2 → the string completes, `busy` falls, CLK/DAT/MK are 0. Re-enabling starts at word 0 of string 3.
- **Reset mid-word:** assert `reset` during bit 5 of word 3 → outputs 0 immediately. The next `en` starts with header 0x0001.
